// File: rtl/board_io_conditioner.sv
// Board-level glue: power-on/external reset stretcher for the core, plus per-channel
// pin synchroniser, stability filter and registered rise/fall edge pulses.
module board_io_conditioner #(
    parameter int                  POR_CYCLES    = 64,
    parameter int                  CHANNELS      = 2,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  FILTER_CYCLES = 1,
    parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] pin_in,
    output logic                core_reset,
    output logic                ready,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int PW = $clog2(POR_CYCLES + 1);
    // A single-cycle filter still needs a 1-bit counter so the datapath is never zero-width.
    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [PW-1:0] POR_MAX  = PW'(POR_CYCLES);
    localparam logic [CW-1:0] FILT_MAX = CW'(FILTER_CYCLES - 1);

    logic [PW-1:0] por_cnt_reg;
    logic [PW-1:0] por_cnt_next;
    logic          core_reset_reg;
    logic          core_reset_next;

    always_comb begin
        por_cnt_next    = (por_cnt_reg == POR_MAX) ? por_cnt_reg : por_cnt_reg + 1'b1;
        core_reset_next = (por_cnt_next != POR_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            por_cnt_reg    <= '0;
            core_reset_reg <= 1'b1;
        end else begin
            por_cnt_reg    <= por_cnt_next;
            core_reset_reg <= core_reset_next;
        end
    end

    assign core_reset = core_reset_reg;
    assign ready      = ~core_reset_reg;

    logic [CHANNELS-1:0] stage_reg [SYNC_STAGES];
    logic [CHANNELS-1:0] sync;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    stage_reg[gi] <= RESET_VAL;
                end else if (gi == 0) begin
                    stage_reg[gi] <= pin_in;
                end else begin
                    stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign sync = stage_reg[SYNC_STAGES-1];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          level_reg;
            logic          level_next;
            logic          rise_reg;
            logic          fall_reg;

            // Any disagreement must persist FILTER_CYCLES samples; a bounce restarts the count.
            always_comb begin
                level_next = level_reg;
                cnt_next   = cnt_reg;
                if (sync[gi] == level_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == FILT_MAX) begin
                    level_next = sync[gi];
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            // Pulses are gated with the core reset value that will be visible alongside them.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_reg   <= '0;
                    level_reg <= RESET_VAL[gi];
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    cnt_reg   <= cnt_next;
                    level_reg <= level_next;
                    rise_reg  <= level_next & ~level_reg & ~core_reset_next;
                    fall_reg  <= ~level_next & level_reg & ~core_reset_next;
                end
            end

            assign level_out[gi] = level_reg;
            assign rise[gi]      = rise_reg;
            assign fall[gi]      = fall_reg;
        end
    endgenerate

endmodule

// File: tb/tb_board_io_conditioner.sv
// Directed bench: two conditioner instances (idle-low with 64-cycle POR, idle-high on
// channel 0 with 8-cycle POR), both with a 4-cycle filter behind 2 sync stages.
module tb_board_io_conditioner;

    logic       clk = 1'b0;
    logic       reset_n_a;
    logic       reset_n_b;
    logic [1:0] pin_a;
    logic [1:0] pin_b;
    logic       core_a, ready_a, core_b, ready_b;
    logic [1:0] level_a, rise_a, fall_a;
    logic [1:0] level_b, rise_b, fall_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    board_io_conditioner #(
        .POR_CYCLES(64), .CHANNELS(2), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(2'b00)
    ) dut_a (
        .clk(clk), .reset_n(reset_n_a), .pin_in(pin_a), .core_reset(core_a), .ready(ready_a),
        .level_out(level_a), .rise(rise_a), .fall(fall_a)
    );

    board_io_conditioner #(
        .POR_CYCLES(8), .CHANNELS(2), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(2'b01)
    ) dut_b (
        .clk(clk), .reset_n(reset_n_b), .pin_in(pin_b), .core_reset(core_b), .ready(ready_b),
        .level_out(level_b), .rise(rise_b), .fall(fall_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        pin_a     = 2'b00;
        pin_b     = 2'b01;
        repeat (3) step();

        // Reset state
        chk("rst_core_a",  32'(core_a),  32'd1);
        chk("rst_ready_a", 32'(ready_a), 32'd0);
        chk("rst_level_a", 32'(level_a), 32'd0);
        chk("rst_rise_a",  32'(rise_a),  32'd0);
        chk("rst_fall_a",  32'(fall_a),  32'd0);
        chk("rst_level_b", 32'(level_b), 32'd1);

        // POR: core_reset high for exactly 64 edges after release
        reset_n_a = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            step();
            chk($sformatf("por_core_e%0d", i), 32'(core_a), (i < 64) ? 32'd1 : 32'd0);
        end
        chk("por_ready", 32'(ready_a), 32'd1);
        repeat (5) step();
        chk("por_stays", 32'(core_a), 32'd0);

        // Reset pulse at POR count 30 restarts the counter
        reset_n_a = 1'b0;
        step();
        reset_n_a = 1'b1;
        repeat (30) step();
        chk("count30_core", 32'(core_a), 32'd1);
        reset_n_a = 1'b0;
        step();
        chk("pulse_core",  32'(core_a),  32'd1);
        chk("pulse_ready", 32'(ready_a), 32'd0);
        reset_n_a = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i >= 62)
                chk($sformatf("repor_core_e%0d", i), 32'(core_a), (i < 64) ? 32'd1 : 32'd0);
        end

        // ch0 0->1 held: level rises on 6th edge counting the sampling edge
        pin_a = 2'b01;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk($sformatf("lat_level_e%0d", i), 32'(level_a), (i >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("lat_rise_e%0d", i),  32'(rise_a),  (i == 6) ? 32'd1 : 32'd0);
        end

        // 3-high / 3-low glitch then stable high
        pin_a = 2'b00;
        repeat (10) step();
        chk("glitch_pre_level", 32'(level_a), 32'd0);
        for (int i = 1; i <= 13; i++) begin
            pin_a = (i <= 3 || i >= 7) ? 2'b01 : 2'b00;
            step();
            chk($sformatf("glitch_level_e%0d", i), 32'(level_a), (i >= 12) ? 32'd1 : 32'd0);
            chk($sformatf("glitch_rise_e%0d", i),  32'(rise_a),  (i == 12) ? 32'd1 : 32'd0);
        end

        // Both channels change on the same edge
        pin_a = 2'b10;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 5) begin
                chk("both_level_e5", 32'(level_a), 32'h1);
                chk("both_rise_e5",  32'(rise_a),  32'h0);
            end
            if (i == 6) begin
                chk("both_level_e6", 32'(level_a), 32'h2);
                chk("both_rise_e6",  32'(rise_a),  32'h2);
                chk("both_fall_e6",  32'(fall_a),  32'h1);
            end
            if (i == 7) begin
                chk("both_rise_e7", 32'(rise_a), 32'h0);
                chk("both_fall_e7", 32'(fall_a), 32'h0);
            end
        end

        // Reset mid-filter discards the pending change and restores idle level
        pin_a = 2'b00;
        repeat (4) step();
        reset_n_a = 1'b0;
        step();
        chk("midfilt_level", 32'(level_a), 32'h0);
        chk("midfilt_core",  32'(core_a),  32'd1);
        reset_n_a = 1'b1;

        // Idle-high channel: no edges from reset; fall suppressed while core_reset high
        reset_n_b = 1'b1;
        pin_b     = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("b_level_e%0d", i), 32'(level_b), (i >= 6) ? 32'h0 : 32'h1);
            chk($sformatf("b_core_e%0d", i),  32'(core_b),  (i < 8) ? 32'd1 : 32'd0);
            chk($sformatf("b_rise_e%0d", i),  32'(rise_b),  32'h0);
            chk($sformatf("b_fall_e%0d", i),  32'(fall_b),  32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
